// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit MEM-stage load/store onto a 16-bit
// asynchronous SRAM as two half-word phases (LOW = bits 15:0, HIGH = bits 31:16).
// Optional feature macro: SRAM_WAIT_STATES_EN. When it is defined, each phase
// lasts WAIT_CYCLES+1 clocks. When it is undefined, each phase lasts one clock
// and WAIT_CYCLES is ignored.
// Debug: state_dbg shows the FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE).
//
// Handshake: ready is a stall request to the pipeline, not a valid/ready pair.
// A request seen in IDLE pulls ready low in the same cycle. ready stays low
// through LOW and HIGH and returns high in DONE, which is when read_data holds
// the load result. The pipeline is frozen while ready is low, so write_data is
// used live. The operation type and the address are captured on IDLE->LOW.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  inout  wire  [15:0] sram_dq,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2} op_t;

  state_t      state, state_nx;
  op_t         op_q, op_nx;
  logic [16:0] word_q, word_nx;
  logic [31:0] offset;
  logic        phase_last;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign offset    = address - 32'(BASE_ADDR);
  assign state_dbg = state;

  // Only the 17-bit word index is addressable on the SRAM.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_WAIT_STATES_EN
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  logic [CW-1:0] phase_cnt;

  // Phase counter: restarts at 0 whenever the state changes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    phase_cnt <= '0;
    else if (state_nx != state)                  phase_cnt <= '0;
    else if (state == LOW || state == HIGH)      phase_cnt <= phase_cnt + CW'(1);
  end

  assign phase_last = (phase_cnt == CW'(WAIT_CYCLES));
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign phase_last = 1'b1;
`endif

  // State, latched operation and latched word address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= OP_NONE;
      word_q <= '0;
    end else begin
      state  <= state_nx;
      op_q   <= op_nx;
      word_q <= word_nx;
    end
  end

  // Next-state logic. When both requests are set, the store wins.
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    word_nx  = word_q;
    case (state)
      IDLE: if (rd_en || wr_en) begin
        state_nx = LOW;
        op_nx    = wr_en ? OP_WR : OP_RD;
        word_nx  = offset[18:2];
      end
      LOW:  if (phase_last) state_nx = HIGH;
      HIGH: if (phase_last) state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        op_nx    = OP_NONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SRAM pins and the stall output, decoded from the current state
  always_comb begin
    ready     = 1'b1;
    sram_addr = '0;
    sram_we_n = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = write_data[15:0];
    case (state)
      IDLE: ready = !(rd_en || wr_en);
      LOW: begin
        ready     = 1'b0;
        sram_addr = {word_q, 1'b0};
        if (op_q == OP_WR) begin
          sram_we_n = 1'b0;
          dq_oe     = 1'b1;
          dq_out    = write_data[15:0];
        end
      end
      HIGH: begin
        ready     = 1'b0;
        sram_addr = {word_q, 1'b1};
        if (op_q == OP_WR) begin
          sram_we_n = 1'b0;
          dq_oe     = 1'b1;
          dq_out    = write_data[31:16];
        end
      end
      default: ready = 1'b1;
    endcase
  end

  assign sram_dq = dq_oe ? dq_out : 16'bz;

  // Load capture: each half is sampled on the last cycle of its phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (op_q == OP_RD && phase_last) begin
      if (state == LOW)  read_data[15:0]  <= sram_dq;
      if (state == HIGH) read_data[31:16] <= sram_dq;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized load/store traffic against a word-level
// reference memory, plus directed cases for both-requests, mid-access input
// changes and reset during a store.
module tb_sram_controller;

  localparam int BASE_ADDR   = 1024;
  localparam int WAIT_CYCLES = 2;
`ifdef SRAM_WAIT_STATES_EN
  localparam int P = WAIT_CYCLES + 1;
`else
  localparam int P = 1;
`endif
  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  wire  [15:0] sram_dq;
  logic [1:0]  state_dbg;

  // SRAM device model (half-word array) and word-level reference model
  logic [15:0] sram_mem [0:2*NW-1];
  logic        sram_oe = 1'b1;
  logic [31:0] ref_mem [0:NW-1];
  logic [31:0] exp_rd;
  logic [31:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  sram_controller #(.BASE_ADDR(BASE_ADDR), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq(sram_dq),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives the bus whenever the write strobe is high
  assign sram_dq = (sram_oe && sram_we_n) ? sram_mem[sram_addr[4:0]] : 16'bz;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[4:0]] = sram_dq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access, checked cycle by cycle
  task automatic do_access(input bit rd, input bit wr, input int w,
                           input logic [31:0] data, input bit disturb);
    bit          is_wr;
    bit          hi;
    logic [16:0] wi;
    is_wr = wr;
    wi    = w[16:0];
    if (is_wr) ref_mem[w] = data;
    else if (rd) exp_rd = ref_mem[w];
    exp_q.push_back(exp_rd);

    @(negedge clk);
    rd_en      = rd;
    wr_en      = wr;
    address    = 32'(BASE_ADDR + 4 * w) + 32'($urandom_range(0, 3));
    write_data = data;
    #1;
    check("req_ready", {31'b0, ready}, 32'd0);
    check("req_state", {30'b0, state_dbg}, 32'd0);

    for (int k = 1; k <= 2 * P; k++) begin
      @(negedge clk);
      if (disturb) begin
        rd_en   = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        address = $urandom;
      end
      #1;
      hi = (k > P);
      check(hi ? "hi_addr" : "lo_addr", {14'b0, sram_addr}, {14'b0, wi, hi});
      check("phase_we_n", {31'b0, sram_we_n}, {31'b0, !is_wr});
      check("phase_ready", {31'b0, ready}, 32'd0);
      if (is_wr) check("store_dq", {16'b0, sram_dq}, {16'b0, hi ? data[31:16] : data[15:0]});
    end

    @(negedge clk);
    rd_en = 1'($urandom_range(0, 1));
    wr_en = 1'($urandom_range(0, 1));
    #1;
    check("done_ready", {31'b0, ready}, 32'd1);
    check("done_state", {30'b0, state_dbg}, 32'd3);
    check("read_data", read_data, exp_q.pop_front());

    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    #1;
    check("idle_state", {30'b0, state_dbg}, 32'd0);
    check("idle_ready", {31'b0, ready}, 32'd1);
    check("idle_addr", {14'b0, sram_addr}, 32'd0);
    check("idle_we_n", {31'b0, sram_we_n}, 32'd1);
    if (is_wr) check("sram_word", {sram_mem[2*w+1], sram_mem[2*w]}, ref_mem[w]);
  endtask

  // Store aborted by reset in its first HIGH cycle: only the low half lands
  task automatic reset_mid_store(input int w, input logic [31:0] data);
    @(negedge clk);
    rd_en      = 1'b0;
    wr_en      = 1'b1;
    address    = 32'(BASE_ADDR + 4 * w);
    write_data = data;
    repeat (P + 1) @(negedge clk);
    #1;
    check("pre_rst_state", {30'b0, state_dbg}, 32'd2);
    check("pre_rst_we_n", {31'b0, sram_we_n}, 32'd0);
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_addr", {14'b0, sram_addr}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_dq_released", {16'b0, sram_dq}, {16'b0, sram_mem[0]});
    ref_mem[w] = {ref_mem[w][31:16], data[15:0]};
    exp_rd     = '0;
    @(negedge clk);
    #1;
    check("rst_hold_we_n", {31'b0, sram_we_n}, 32'd1);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int          op;
    for (int w = 0; w < NW; w++) begin
      r              = $urandom;
      ref_mem[w]     = r;
      sram_mem[2*w]   = r[15:0];
      sram_mem[2*w+1] = r[31:16];
    end
    exp_rd = '0;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {30'b0, state_dbg}, 32'd0);
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_read_data", read_data, 32'd0);
    check("reset_we_n", {31'b0, sram_we_n}, 32'd1);
    check("reset_addr", {14'b0, sram_addr}, 32'd0);
    rst = 1'b1;

    // Both requests set: store wins and read_data stays 0
    do_access(1'b1, 1'b1, 0, 32'h1234_5678, 1'b0);
    // Directed store/load round trips, including word 1 (1028) and word 3 (1036)
    do_access(1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);
    do_access(1'b1, 1'b0, 0, $urandom, 1'b0);
    do_access(1'b1, 1'b0, 1, $urandom, 1'b0);
    do_access(1'b0, 1'b1, 3, 32'hCAFE_F00D, 1'b0);
    do_access(1'b1, 1'b0, 3, $urandom, 1'b0);

    // Random traffic with optional mid-access input changes
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, $urandom_range(0, NW - 1), $urandom,
                1'($urandom_range(0, 1)));
    end

    // Reset during HIGH of a store, then read back the partial word
    reset_mid_store(5, $urandom);
    do_access(1'b1, 1'b0, 5, $urandom, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
